// File: rtl/cordic_cart_to_cyl.sv
// Iterative vectoring-mode CORDIC: Cartesian (x, y, z) to cylindrical (r, theta, z).
// One micro-rotation per clock; valid/ready handshake on input and output.
module cordic_cart_to_cyl #(
   parameter int unsigned W    = 8,
   parameter int unsigned ITER = 8,
   parameter int unsigned AW   = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [W-1:0]  x_in,
   input  logic [W-1:0]  y_in,
   input  logic [W-1:0]  z_in,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [W-1:0]  r_out,
   output logic [AW-1:0] theta_out,
   output logic [W-1:0]  z_out,
   output logic          busy
);

   // xr/yr keep GB fractional guard bits below the W+2 integer bits; without them
   // shift truncation alone costs several theta LSBs on short vectors such as (3, 4).
   localparam int unsigned GB = 10;
   localparam int unsigned XW = W + 2 + GB;
   localparam int unsigned PW = XW + 16;

   localparam logic [3:0]    I_LAST  = 4'(ITER - 1);
   localparam logic [15:0]   ANG_RND = (AW < 16) ? 16'(32'd1 << (15 - AW)) : 16'd0;
   localparam logic [PW-1:0] K_GAIN  = PW'(39797);
   localparam logic [PW-1:0] R_RND   = PW'(1) << (15 + GB);
   localparam logic [PW-1:0] R_MAX   = PW'({W{1'b1}});

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ITER,
      ST_SCALE,
      ST_DONE
   } state_t;

   function automatic logic [15:0] atan_lut(input logic [3:0] idx);
      logic [15:0] t;
      t = '0;
      case (idx)
         4'd0:  t = 16'd8192;
         4'd1:  t = 16'd4836;
         4'd2:  t = 16'd2555;
         4'd3:  t = 16'd1297;
         4'd4:  t = 16'd651;
         4'd5:  t = 16'd326;
         4'd6:  t = 16'd163;
         4'd7:  t = 16'd81;
         4'd8:  t = 16'd41;
         4'd9:  t = 16'd20;
         4'd10: t = 16'd10;
         4'd11: t = 16'd5;
         4'd12: t = 16'd3;
         4'd13: t = 16'd1;
         4'd14: t = 16'd1;
         4'd15: t = 16'd0;
         default: t = '0;
      endcase
      return t;
   endfunction

   state_t               state, state_nxt;
   logic signed [XW-1:0] xr, yr;
   logic signed [XW-1:0] x_ext, y_ext;
   logic signed [XW-1:0] xr_sh, yr_sh;
   logic [15:0]          acc;
   logic [15:0]          ang;
   logic [3:0]           i_cnt;
   logic                 zero_in;
   logic [PW-1:0]        r_full;

   assign x_ext  = {{2{x_in[W-1]}}, x_in, {GB{1'b0}}};
   assign y_ext  = {{2{y_in[W-1]}}, y_in, {GB{1'b0}}};
   assign xr_sh  = xr >>> i_cnt;
   assign yr_sh  = yr >>> i_cnt;
   assign ang    = atan_lut(i_cnt);
   // xr never goes negative once pre-rotated into the right half-plane
   assign r_full = ((PW'(unsigned'(xr)) * K_GAIN) + R_RND) >> (16 + GB);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b1;
      case (state)
         ST_IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (in_valid) state_nxt = ST_ITER;
         end
         ST_ITER: begin
            if (i_cnt == I_LAST) state_nxt = ST_SCALE;
         end
         ST_SCALE: state_nxt = ST_DONE;
         ST_DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         xr        <= '0;
         yr        <= '0;
         acc       <= '0;
         i_cnt     <= '0;
         zero_in   <= 1'b0;
         r_out     <= '0;
         theta_out <= '0;
         z_out     <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  z_out   <= z_in;
                  zero_in <= (x_in == '0) && (y_in == '0);
                  i_cnt   <= '0;
                  if (x_in[W-1]) begin
                     xr  <= -x_ext;
                     yr  <= -y_ext;
                     acc <= 16'h8000;
                  end else begin
                     xr  <= x_ext;
                     yr  <= y_ext;
                     acc <= '0;
                  end
               end
            end
            ST_ITER: begin
               if (!yr[XW-1]) begin
                  xr  <= xr + yr_sh;
                  yr  <= yr - xr_sh;
                  acc <= acc + ang;
               end else begin
                  xr  <= xr - yr_sh;
                  yr  <= yr + xr_sh;
                  acc <= acc - ang;
               end
               i_cnt <= i_cnt + 4'd1;
            end
            ST_SCALE: begin
               if (zero_in) begin
                  r_out     <= '0;
                  theta_out <= '0;
               end else begin
                  r_out     <= (r_full > R_MAX) ? '1 : r_full[W-1:0];
                  theta_out <= AW'((acc + ANG_RND) >> (16 - AW));
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/cordic_cart_to_cyl.md
# cordic_cart_to_cyl

Parametrised iterative CORDIC (vectoring mode) converter from Cartesian (x, y, z) to cylindrical (r, theta, z). It replaces the earlier single-cycle |x−y| / (x+y)/2 approximation with a true magnitude and a four-quadrant angle, using a valid/ready handshake on both sides. It sits in the same ui_in → uo_out datapath slot and is the arithmetic core behind the TinyTapeout wrapper.

## Interface
- W, default 8: width of signed x_in/y_in, of z_in/z_out, and of unsigned r_out.
- ITER, default 8: CORDIC micro-rotations, legal range 1..16.
- AW, default 8: theta_out width; full circle = 2^AW LSB.

- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  x_in, y_in and z_in are valid.
- in_ready  output  1  block accepts a new sample.
- x_in  input  W  signed two's-complement x.
- y_in  input  W  signed two's-complement y.
- z_in  input  W  z value, passed through untouched.
- out_valid  output  1  r_out, theta_out and z_out are valid.
- out_ready  input  1  consumer accepts the result.
- r_out  output  W  unsigned magnitude sqrt(x²+y²).
- theta_out  output  AW  unsigned angle; 0 = +x axis, counter-clockwise, wraps modulo 2^AW.
- z_out  output  W  registered copy of the accepted z_in.
- busy  output  1  high in every state except IDLE.

## Operation
- The block has four states: IDLE, ITER, SCALE and DONE.
- IDLE: in_ready = 1. An input is accepted when in_valid && in_ready.
  - On acceptance, latch z_in.
  - Pre-rotate: if x_in < 0, set xr = −x_in, yr = −y_in and acc = 32768; else xr = x_in, yr = y_in and acc = 0.
  - xr and yr are signed, W+2 bits wide. acc is unsigned, 16 bits, and wraps.
  - Clear the iteration counter i and go to ITER.
- ITER: one micro-rotation per cycle, for i = 0..ITER−1.
  - If yr ≥ 0: xr += yr>>>i, yr −= xr>>>i, acc += T[i].
  - Otherwise: xr −= yr>>>i, yr += xr>>>i, acc −= T[i].
  - All three updates use the pre-update xr and yr.
  - After i = ITER−1, go to SCALE.
- Angle table T[0..15], in units of 2^16 per circle: 8192, 4836, 2555, 1297, 651, 326, 163, 81, 41, 20, 10, 5, 3, 1, 1, 0.
- SCALE: compute the outputs, then go to DONE.
  - r = (xr × 39797 + 2^15) >> 16. This is gain compensation with K ≈ 0.60725. Saturate r to 2^W−1.
  - theta = (acc + 2^(15−AW)) >> (16−AW), modulo 2^AW. Example: 65535 at AW=8 wraps to 0.
  - If the latched x_in == 0 and y_in == 0, force r = 0 and theta = 0.
- DONE: out_valid = 1. r_out, theta_out and z_out stay stable until out_valid && out_ready, then go to IDLE.
- in_ready is 0 in ITER, SCALE and DONE; there is no overlap between samples.

## Timing
- Reset (asynchronous, any state, including mid-iteration): state = IDLE.
  - in_ready = 1 immediately; out_valid = 0 and busy = 0.
  - r_out, theta_out and z_out = 0; internal xr, yr, acc and i = 0.
  - The in-flight sample is discarded.
- Latency: if a sample is accepted at edge k, out_valid rises after edge k+ITER+1 (ITER cycles in ITER, one in SCALE).
- in_ready is low from edge k.
- When out_ready is held at 1, the output handshake completes on the first DONE edge, and in_ready rises after that edge.
- Peak throughput is one sample per ITER+3 cycles.
- Backpressure: DONE holds indefinitely, and the outputs must not change while out_valid && !out_ready.
- in_valid asserted while busy is ignored; no sample is captured.
- Accuracy at W=8, ITER=8, AW=8: r within ±1 LSB of round(sqrt(x²+y²)), theta within ±1 LSB of the ideal value, including across the 0/2^AW wrap.

## Test plan
All cases use W=8, ITER=8, AW=8, out_ready=1 unless stated.
- Axes:
  - (x, y) = (100, 0) → r = 100, theta = 0.
  - (0, 100) → r = 100, theta = 64.
  - (−100, 0) → r = 100, theta = 128.
  - (0, −100) → r = 100, theta = 192.
  - All ±1 LSB.
- Off-axis and extremes:
  - (3, 4) → r = 5, theta = 38.
  - (−128, −128) → r = 181, theta = 160.
  - (127, −1) → r = 127, theta = 0 (the value 255 is also accepted via wrap).
  - All ±1.
- Origin: (0, 0), z = 0x5A → r = 0, theta = 0, z_out = 0x5A. out_valid appears exactly 9 cycles after acceptance.
- Handshake:
  - Hold out_ready = 0 for 20 cycles: outputs stay stable and in_ready stays 0.
  - Pulse in_valid while busy: that sample is ignored.
  - Release out_ready: in_ready rises the next cycle.
- Reset during ITER (cycle 4 after acceptance) → all outputs 0 and in_ready = 1 immediately, asynchronously. The next accepted sample (50, 50) → r = 71, theta = 32.
- Back-to-back: 100 random (x, y, z) samples with random out_ready are compared against a floating-point model within ±1 LSB, and z_out matches z_in exactly.
